// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register: PC, req/ack imem port, hold buffer for stalled acks.
// Latency 1 cycle ack->idInstr; stall holds PC and IF/ID, branch/jump redirects flush and override stall.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  output logic [31:0] imemAddr,
  output logic        imemReq,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] idInstr,
  output logic [31:0] idPcPlus4,
  output logic        idValid,
  output logic [5:0]  opCode
);

  typedef enum logic {FETCH = 1'b0, HELD = 1'b1} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] hold_q;
  logic [31:0] instr_q;
  logic [31:0] pcp4_q;
  logic        valid_q;
  logic        req_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] redir_pc_d;
  logic        redir_d;
  logic        ack_d;

  always_comb begin
    pc_plus4_d = pc_q + 32'd4;
    redir_d    = branchTaken | (jump & valid_q);
    redir_pc_d = branchTaken ? branchTarget : {pcp4_q[31:28], instr_q[25:0], 2'b00};
    // An ack is only meaningful while a request is actually outstanding.
    ack_d      = imemAck & req_q;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= 32'd0;
      instr_q <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else if (redir_d) begin
      state_q <= FETCH;
      pc_q    <= redir_pc_d;
      hold_q  <= 32'd0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          req_q <= 1'b1;
          if (ack_d && !stall) begin
            instr_q <= imemData;
            pcp4_q  <= pc_plus4_d;
            valid_q <= 1'b1;
            pc_q    <= pc_plus4_d;
          end else if (ack_d && stall) begin
            hold_q  <= imemData;
            pc_q    <= pc_plus4_d;
            state_q <= HELD;
            req_q   <= 1'b0;
          end else if (!stall) begin
            instr_q <= 32'd0;
            valid_q <= 1'b0;
          end
        end
        HELD: begin
          // PC already points past the held word, so it is the word's PC+4.
          if (!stall) begin
            instr_q <= hold_q;
            pcp4_q  <= pc_q;
            valid_q <= 1'b1;
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

  assign imemAddr  = pc_q;
  assign imemReq   = req_q;
  assign idInstr   = instr_q;
  assign idPcPlus4 = pcp4_q;
  assign idValid   = valid_q;
  assign opCode    = instr_q[31:26];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the single-issue MIPS datapath. Holds the PC, drives a request/acknowledge instruction-memory port, and presents the fetched word plus PC+4 to decode. The 6-bit `opCode` output feeds the control unit. Redirects are taken from taken branches (resolved downstream) and from jumps decoded in ID. Hazard stalls and flushes are handled here.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID contents.
- `branchTaken`  in  1  branch resolved taken this cycle.
- `branchTarget`  in  32  target address for `branchTaken`.
- `jump`  in  1  control unit's jump decode of `opCode`.
- `imemAddr`  out  32  fetch address, equal to the PC register.
- `imemReq`  out  1  fetch request, level.
- `imemAck`  in  1  `imemData` valid this cycle for `imemAddr`.
- `imemData`  in  32  instruction word.
- `idInstr`  out  32  IF/ID instruction.
- `idPcPlus4`  out  32  IF/ID PC+4 of `idInstr`.
- `idValid`  out  1  IF/ID holds a real instruction; 0 = bubble.
- `opCode`  out  6  `idInstr[31:26]`, combinational.

## Operation
- State machine:
  - FETCH: `imemReq`=1.
  - HELD: `imemReq`=0; `holdInstr` buffer occupied.
- Redirect priority, evaluated each edge: reset > branch > jump > stall > normal.
  - Branch condition is `branchTaken`=1.
  - Jump condition is `jump`=1 and `idValid`=1. `jump` is ignored when `idValid`=0.
- Branch redirect: PC <= `branchTarget`. IF/ID flushed (`idInstr`=0, `idValid`=0). `holdInstr` discarded. State <= FETCH. Any same-cycle `imemAck` data is dropped.
- Jump redirect: PC <= {`idPcPlus4`[31:28], `idInstr`[25:0], 2'b00}. Flush, discard and state update are the same as for a branch redirect.
- Redirects override `stall`.
- FETCH, no redirect:
  - `imemAck`=1, `stall`=0: IF/ID <= {`imemData`, PC+4, valid=1}; PC <= PC+4.
  - `imemAck`=1, `stall`=1: `holdInstr` <= `imemData`; PC <= PC+4; IF/ID unchanged; state <= HELD. Captured PC+4 is the new PC.
  - `imemAck`=0, `stall`=0: IF/ID <= bubble; PC unchanged.
  - `imemAck`=0, `stall`=1: nothing changes.
- HELD, no redirect:
  - `stall`=1: everything held.
  - `stall`=0: IF/ID <= {`holdInstr`, PC, valid=1}; state <= FETCH. PC already points past the held word.
  - `imemAck` is ignored in HELD.
- Arithmetic: PC+4 is 32-bit modulo 2^32; 32'hFFFF_FFFC wraps to 0. No alignment checks; bits [1:0] pass through as given.

## Timing
- Reset (`rstN`=0, asynchronous) sets:
  - PC=`RESET_PC`, `imemAddr`=`RESET_PC`, `imemReq`=0.
  - `idInstr`=0, `idPcPlus4`=0, `idValid`=0, `opCode`=0.
  - State=FETCH, `holdInstr`=0.
- After reset: `imemReq`=1 from the first cycle after `rstN` deasserts.
- Reset mid-operation (any state) immediately returns all of the above to reset values, including an occupied `holdInstr`.
- `imemAddr` comes directly from the PC register. It may change every cycle, and the memory must not assume an outstanding transaction.
- Latency: instruction acked in cycle N appears on `idInstr` in cycle N+1 (no stall).
- Throughput: one instruction per cycle with `imemAck` held at 1.
- Redirect asserted in cycle N:
  - `imemAddr`=target in N+1.
  - Earliest target instruction valid in IF/ID in N+2.
  - Penalty of 1 bubble for jump; branch penalty per the resolving stage.
- Stall release from HELD produces valid IF/ID on the next edge with no memory access.

## Test plan
- Reset and stream: `RESET_PC`=0x100, `imemAck`=1, words A,B,C.
  - Required: `idInstr` A/B/C in cycles 2/3/4.
  - `idPcPlus4`=0x104/0x108/0x10C.
  - `imemReq`=0 while `rstN`=0.
- Jump: `idInstr`=0x0800_0040 (opCode 000010), `idPcPlus4`=0x0000_0104, `jump`=1.
  - Required: next `imemAddr`=0x0000_0100.
  - Next `idValid`=0.
  - Same-cycle ack dropped.
- Branch vs stall and jump: `branchTaken`=1, `branchTarget`=0x200, `stall`=1, `jump`=1 in the same cycle.
  - Required: `imemAddr`=0x200 next cycle and IF/ID flushed.
- Stall with ack: at PC=0x108 `imemAck`=1 with word W, `stall`=1 for 3 cycles.
  - Required: HELD, `imemReq`=0, `imemAddr`=0x10C, IF/ID unchanged.
  - On release: `idInstr`=W, `idPcPlus4`=0x10C.
- Slow memory: `imemAck`=0 for 2 cycles at PC=0x120.
  - Required: `idValid`=0 during the wait, `imemAddr` stays 0x120.
  - Then ack gives valid word, PC 0x124.
- Wrap and async reset: PC=0xFFFF_FFFC with ack.
  - Required: `idPcPlus4`=0 and PC=0.
  - Then `rstN` low mid-cycle while in HELD: outputs return to reset values before the next edge.
